// File: rtl/irig_single_clk_fsm.sv
// IRIG edge-to-pulse front end: synchronizes irig_d0 and emits a one-clock pulse
// per rising edge through a three-state Moore FSM.
module irig_single_clk_fsm #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       irig_d0,
  output logic       irig_d0_out,
  output logic [1:0] state_vec
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PULSE    = 2'b01,
    WAIT_LOW = 2'b10,
    ILLEGAL  = 2'b11
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;

  // Clearing the synchronizer on reset makes a line already high at release look like a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irig_d0};
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:     next_state = sync_in ? PULSE : IDLE;
      PULSE:    next_state = sync_in ? WAIT_LOW : IDLE;
      WAIT_LOW: next_state = sync_in ? WAIT_LOW : IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Outputs decode only the state register, so the pulse cannot glitch.
  assign irig_d0_out = (state == PULSE);
  assign state_vec   = state;

endmodule

// File: tb/tb_irig_single_clk_fsm.sv
// Randomized scoreboard bench for irig_single_clk_fsm: expected output/state per edge is
// derived from the sampled input history and checked by an independent monitor.
`timescale 1ns/100ps
module tb_irig_single_clk_fsm;

  logic       clk;
  logic       rst;
  logic       irig_d0;
  logic       irig_d0_out;
  logic [1:0] state_vec;

  int n_checks = 0;
  int n_fails  = 0;

  logic [2:0] exp_q[$];
  logic       hist[$];

  irig_single_clk_fsm #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .irig_d0    (irig_d0),
    .irig_d0_out(irig_d0_out),
    .state_vec  (state_vec)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic checkOutput(input string name, input logic exp_out, input logic [1:0] exp_state);
    n_checks++;
    if (irig_d0_out !== exp_out || state_vec !== exp_state) begin
      n_fails++;
      $display("[TB] FAIL %s at %0t: got out=%0b state=%02b, expected out=%0b state=%02b",
               name, $time, irig_d0_out, state_vec, exp_out, exp_state);
    end
  endtask

  // History index k is the value sampled at the k-th edge since reset release.
  // After edge n the synchronized line shows hist[n-2]; the line one edge earlier is hist[n-3].
  task automatic pushExpected(input logic v);
    int   n;
    logic now_hi;
    logic prev_hi;
    logic [1:0] st;
    hist.push_back(v);
    n       = hist.size() - 1;
    now_hi  = (n >= 2) ? hist[n-2] : 1'b0;
    prev_hi = (n >= 3) ? hist[n-3] : 1'b0;
    if (!now_hi)      st = 2'b00;
    else if (prev_hi) st = 2'b10;
    else              st = 2'b01;
    exp_q.push_back({now_hi & ~prev_hi, st});
  endtask

  task automatic applyStimulus(input logic v);
    @(negedge clk);
    irig_d0 = v;
    pushExpected(v);
  endtask

  task automatic applyRun(input logic v, input int len);
    for (int i = 0; i < len; i++) applyStimulus(v);
  endtask

  task automatic holdReset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      irig_d0 = 1'($urandom_range(0, 1));
      #0.2;
      checkOutput("reset_hold", 1'b0, 2'b00);
    end
    hist.delete();
    exp_q.delete();
  endtask

  task automatic releaseReset(input logic v);
    @(negedge clk);
    rst     = 1'b0;
    irig_d0 = v;
    pushExpected(v);
  endtask

  // Assert reset just after the edge where the state reaches the target, then check it cleared at once.
  task automatic midReset(input string name, input int highs);
    applyRun(1'b0, 4);
    applyRun(1'b1, highs);
    @(posedge clk);
    #0.7;
    rst = 1'b1;
    #0.1;
    checkOutput(name, 1'b0, 2'b00);
    holdReset(3);
  endtask

  // Monitor: one expected entry per clock edge while out of reset.
  always @(posedge clk) begin
    #0.5;
    if (!rst && exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      checkOutput("scoreboard", e[2], e[1:0]);
    end
  end

  initial begin
    rst     = 1'b1;
    irig_d0 = 1'b0;
    #0.5;
    checkOutput("reset_initial", 1'b0, 2'b00);
    holdReset(4);
    releaseReset(1'b0);

    applyRun(1'b0, 3);
    applyRun(1'b1, 5);
    applyRun(1'b0, 3);
    applyRun(1'b1, 5);
    applyRun(1'b0, 4);
    applyRun(1'b1, 1);
    applyRun(1'b0, 4);

    // Reset while PULSE (3 highs) and while WAIT_LOW (4 highs).
    midReset("reset_in_pulse", 3);
    releaseReset(1'b0);
    midReset("reset_in_wait_low", 4);

    // Release with the line already high: expect one pulse, then WAIT_LOW until it falls.
    releaseReset(1'b1);
    applyRun(1'b1, 6);
    applyRun(1'b0, 4);

    for (int r = 0; r < 60; r++) begin
      applyRun(1'(r % 2), int'($urandom_range(1, 6)));
    end
    applyRun(1'b0, 4);

    @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
